// File: rtl/pipelined_adder_if.sv
// rtl/pipelined_adder_if.sv - operand/result handshake bundle for pipelined_adder (ovf present with ADDER_OVERFLOW_EN)
interface pipelined_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef ADDER_OVERFLOW_EN
    logic             ovf;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );
    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
`endif
endinterface

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - STAGES-deep ripple-sliced adder with valid/ready flow control
// Optional signed overflow output enabled by ADDER_OVERFLOW_EN.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic              clk,
    input  logic              rst,
    pipelined_adder_if.slave  bus
);
    localparam int SW = WIDTH / STAGES;

    logic en;

    // Whole pipe moves together; it only stalls when the output holds an unconsumed result.
    assign en           = bus.out_ready || !g_stage[STAGES-1].v_r;
    assign bus.in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        // IW: operand bits not yet added on entry to this stage; SWD: sum bits done after it
        localparam int IW  = WIDTH - k * SW;
        localparam int SWD = (k + 1) * SW;

        logic            v_in;
        logic            c_in;
        logic [IW-1:0]   a_in;
        logic [IW-1:0]   b_in;
        logic [SW:0]     add;
        logic [SWD-1:0]  s_d;
        logic            v_r;
        logic            c_r;
        logic [SWD-1:0]  s_r;

        assign add = {1'b0, a_in[SW-1:0]} + {1'b0, b_in[SW-1:0]} + {{SW{1'b0}}, c_in};

        if (k == 0) begin : g_first
            assign v_in = bus.in_valid;
            assign c_in = bus.cin;
            assign a_in = bus.a;
            assign b_in = bus.b;
            assign s_d  = add[SW-1:0];
        end else begin : g_next
            assign v_in = g_stage[k-1].v_r;
            assign c_in = g_stage[k-1].c_r;
            assign a_in = g_stage[k-1].g_fwd.a_r;
            assign b_in = g_stage[k-1].g_fwd.b_r;
            assign s_d  = {add[SW-1:0], g_stage[k-1].s_r};
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_r <= 1'b0;
                c_r <= 1'b0;
                s_r <= '0;
            end else if (en) begin
                v_r <= v_in;
                c_r <= add[SW];
                s_r <= s_d;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            logic [IW-SW-1:0] a_r;
            logic [IW-SW-1:0] b_r;

            always_ff @(posedge clk) begin
                if (en) begin
                    a_r <= a_in[IW-1:SW];
                    b_r <= b_in[IW-1:SW];
                end
            end
        end

`ifdef ADDER_OVERFLOW_EN
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_r;

            // carry into the MSB is a^b^sum at that bit; overflow when it differs from carry out
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_r <= 1'b0;
                end else if (en) begin
                    ovf_r <= a_in[SW-1] ^ b_in[SW-1] ^ add[SW-1] ^ add[SW];
                end
            end
        end
`endif
    end

    assign bus.out_valid = g_stage[STAGES-1].v_r;
    assign bus.sum       = g_stage[STAGES-1].s_r;
    assign bus.cout      = g_stage[STAGES-1].c_r;
`ifdef ADDER_OVERFLOW_EN
    assign bus.ovf       = g_stage[STAGES-1].g_ovf.ovf_r;
`endif

endmodule

// File: doc/pipelined_adder.md
PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning operand/sum width in bits.
REQ-002 The block SHALL have parameter STAGES, default 4, meaning pipeline depth; legal values 1..WIDTH with WIDTH % STAGES == 0.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: a, b and cin are valid this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand set this cycle.
REQ-007 The block SHALL have port a, input, WIDTH bits: operand A, unsigned.
REQ-008 The block SHALL have port b, input, WIDTH bits: operand B, unsigned.
REQ-009 The block SHALL have port cin, input, 1 bit: carry-in.
REQ-010 The block SHALL have port out_valid, output, 1 bit: sum and cout hold a result.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-012 The block SHALL have port sum, output, WIDTH bits: (a + b + cin) mod 2^WIDTH.
REQ-013 The block SHALL have port cout, output, 1 bit: bit WIDTH of a + b + cin.

Function
REQ-014 Transfers SHALL follow valid/ready: input accepted when in_valid && in_ready; output consumed when out_valid && out_ready.
REQ-015 Pipeline advance enable SHALL be en = out_ready || !out_valid, with in_ready = en combinationally; no other path from out_ready to in_ready.
REQ-016 With en high, every stage register SHALL shift one place per cycle, stage 0 loading the accepted input; a cycle without acceptance SHALL load a bubble (valid bit 0).
REQ-017 With en low, all stage registers SHALL hold; sum, cout and out_valid SHALL stay stable until consumed.
REQ-018 Stage k (0..STAGES-1) SHALL add slice [k*W/S +: W/S] of a and b plus the carry registered by stage k-1 (cin for stage 0); lower sum slices and upper operand slices SHALL be carried forward in stage registers.
REQ-019 Latency SHALL be exactly STAGES cycles from acceptance to out_valid with no stall; sustained throughput SHALL be one result per cycle while out_ready is high.
REQ-020 Result order SHALL equal acceptance order; no result SHALL be dropped or duplicated under any in_valid/out_ready pattern.
REQ-021 Acceptance and consumption in the same cycle SHALL both take effect (full pipeline streams without a bubble).
REQ-022 Arithmetic SHALL be unsigned modulo 2^WIDTH, with cout the sole indication of wrap-around.
REQ-023 STAGES = 1 SHALL give a single registered adder with latency 1.

Reset
REQ-024 Asserting rst SHALL immediately clear all stage valid bits, so out_valid = 0, and drive sum = 0 and cout = 0.
REQ-025 Reset mid-operation SHALL discard all in-flight results; after rst deassertion in_ready SHALL be 1 in the first cycle.
REQ-026 Operand/data pipeline registers other than the outputs need not be reset.

Configuration
REQ-027 With macro ADDER_OVERFLOW_EN defined, the block SHALL add output port ovf, 1 bit: signed two's-complement overflow (carry into MSB xor carry out of MSB), aligned with sum and reset to 0.
REQ-028 Without ADDER_OVERFLOW_EN, port ovf and its pipeline logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-029 WIDTH=16, STAGES=4, out_ready=1: a=0xFFFF, b=0x0001, cin=0 accepted at cycle 0 -> out_valid at cycle 4 with sum=0x0000, cout=1.
REQ-030 Back-to-back: 8 random operand sets on 8 consecutive cycles, out_ready=1 -> 8 consecutive out_valid cycles, in order, each matching a reference model; in_ready constant 1.
REQ-031 Backpressure: fill the pipe, hold out_ready=0 for 5 cycles -> in_ready=0, sum/cout stable; release -> all results delivered in order with none lost.
REQ-032 Reset mid-stream: assert rst with 3 results in flight -> out_valid=0, sum=0 at once; no stale result appears after deassertion.
REQ-033 ADDER_OVERFLOW_EN defined: a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; a=0xFFFF, b=0x0001 -> ovf=0, cout=1.
REQ-034 STAGES=1, WIDTH=8: a=0x80, b=0x80, cin=1 -> one cycle later sum=0x01, cout=1.
